// File: rtl/axi_rd_pkg.sv
// ============================================================================
// axi_rd_pkg : shared types and encodings for the AXI4 read initiator
// Rev 1.0
// ============================================================================
`default_nettype none

package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Data width of a buffered response beat; the top-level DATA_W must match.
  localparam int RESP_DATA_W = 32;

  typedef struct packed {
    logic [RESP_DATA_W-1:0] data;
    logic                   last;
    logic                   err;
  } resp_entry_t;

endpackage

`default_nettype wire

// File: rtl/axi_rd_if.sv
// ============================================================================
// axi_rd_if : client request/response and AXI4 AR/R channel bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface axi_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic [2:0]        req_size;
  logic [1:0]        req_burst;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_last;
  logic              resp_err;
  logic              proto_err;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [1:0]        rresp;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    input  req_valid, req_addr, req_len, req_size, req_burst, resp_ready,
           arready, rvalid, rresp, rdata, rlast, rid,
    output req_ready, resp_valid, resp_data, resp_last, resp_err, proto_err,
           arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

  modport slave (
    output req_valid, req_addr, req_len, req_size, req_burst, resp_ready,
           arready, rvalid, rresp, rdata, rlast, rid,
    input  req_ready, resp_valid, resp_data, resp_last, resp_err, proto_err,
           arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

endinterface

`default_nettype wire

// File: rtl/axi_rd_resp_fifo.sv
// ============================================================================
// axi_rd_resp_fifo : 2-entry first-word-fall-through response buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_rd_resp_fifo
  import axi_rd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  resp_entry_t data_i,
  input  logic        pop_i,
  output resp_entry_t head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [1:0]  count_o
);

  resp_entry_t mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        do_push;
  logic        do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/axi_rd_master.sv
// ============================================================================
// axi_rd_master : single-outstanding AXI4 read burst initiator with checks
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_rd_master
  import axi_rd_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = RESP_DATA_W,
  parameter int              ID_W     = 4,
  parameter logic [ID_W-1:0] ID_VALUE = '0
) (
  input  logic   clk,
  input  logic   rst,
  axi_rd_if.master bus
);

  state_e            state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              proto_q, proto_d;

  logic              r_hs;
  logic              last_eff;
  logic              viol;
  logic              beat_err;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  resp_entry_t       push_entry;
  resp_entry_t       head;

  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign bus.arvalid   = arvalid_q;
  assign bus.araddr    = araddr_q;
  assign bus.arlen     = arlen_q;
  assign bus.arsize    = arsize_q;
  assign bus.arburst   = arburst_q;
  assign bus.arid      = ID_VALUE;
  assign bus.proto_err = proto_q;

  // Registered-only ready: depends on state and FIFO occupancy, never on rvalid.
  assign bus.rready = (state_q == ST_DATA) && (fifo_count < 2'd2);
  assign r_hs       = bus.rvalid && bus.rready;

  assign last_eff = bus.rlast || (cnt_q == arlen_q);
  assign viol     = (bus.rid != ID_VALUE)
                  || (bus.rlast && (cnt_q < arlen_q))
                  || (!bus.rlast && (cnt_q == arlen_q));
  assign beat_err = viol || (bus.rresp == RESP_SLVERR) || (bus.rresp == RESP_DECERR);

  assign push_entry = '{data: bus.rdata, last: last_eff, err: beat_err};

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    cnt_d     = cnt_q;
    proto_d   = proto_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          araddr_d  = bus.req_addr;
          arlen_d   = bus.req_len;
          arsize_d  = bus.req_size;
          arburst_d = bus.req_burst;
          arvalid_d = 1'b1;
          cnt_d     = 8'd0;
          proto_d   = 1'b0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          if (viol) proto_d = 1'b1;
          // Counter stops at the final beat so it never exceeds arlen.
          if (last_eff) state_d = ST_IDLE;
          else          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= 8'd0;
      arsize_q  <= 3'd0;
      arburst_q <= 2'd0;
      cnt_q     <= 8'd0;
      proto_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      cnt_q     <= cnt_d;
      proto_q   <= proto_d;
    end
  end

  axi_rd_resp_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (r_hs && !fifo_full),
    .data_i  (push_entry),
    .pop_i   (bus.resp_valid && bus.resp_ready),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.resp_valid = !fifo_empty;
  assign bus.resp_data  = head.data;
  assign bus.resp_last  = head.last;
  assign bus.resp_err   = head.err;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_master.sv
// ============================================================================
// tb_axi_rd_master : directed + randomized bench with a beat-list reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_rd_master;
  import axi_rd_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  axi_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  axi_rd_master #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ID_W     (ID_W),
    .ID_VALUE (4'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  logic  exp_proto;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected beat list: stop at the first beat with rlast or at beat index len.
  task automatic build_model(input int len, input int last_idx, input int bad_idx,
                             input logic [1:0] rresp, input logic [31:0] base);
    exp_q.delete();
    exp_proto = 1'b0;
    for (int k = 0; k <= len; k++) begin
      bit rl, eff, v;
      rl  = (k == last_idx);
      eff = rl || (k == len);
      v   = (k == bad_idx) || (rl && k < len) || (!rl && k == len);
      exp_q.push_back('{base + 32'(k), eff, v || rresp[1]});
      if (v) exp_proto = 1'b1;
      if (eff) break;
    end
  endtask

  task automatic issue_req(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int ar_delay);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = 8'(len);
    bus.req_size  = size;
    bus.req_burst = burst;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_len   = 8'($urandom);
    check("arvalid_rise", bus.arvalid, 1);
    check("araddr", bus.araddr, addr);
    check("arlen", bus.arlen, 8'(len));
    check("arsize", bus.arsize, size);
    check("arburst", bus.arburst, burst);
    check("arid", bus.arid, 0);
    check("req_ready_busy", bus.req_ready, 0);
    check("proto_err_cleared", bus.proto_err, 0);
    check("rready_in_addr", bus.rready, 0);
    for (int i = 0; i < ar_delay; i++) begin
      bus.arready = 1'b0;
      @(posedge clk); @(negedge clk);
      check("arvalid_hold", bus.arvalid, 1);
      check("araddr_hold", bus.araddr, addr);
    end
    bus.arready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.arready = 1'b0;
    check("arvalid_drop", bus.arvalid, 0);
  endtask

  task automatic data_phase(input int len, input int last_idx, input int bad_idx,
                            input logic [1:0] rresp, input logic [31:0] base,
                            input int rr_hold, input bit rnd);
    int nsend, sk, acc, popped, occ, cyc, nexp;
    bit in_data, hs, pop, rv_hold;
    nexp    = exp_q.size();
    nsend   = (last_idx >= 0 && last_idx <= len) ? last_idx + 1 : len + 2;
    sk      = 0; acc = 0; popped = 0; occ = 0; cyc = 0;
    in_data = 1'b1;
    rv_hold = 1'b0;
    while (popped < nexp) begin
      if (cyc >= 3000) begin
        check("data_timeout", popped, nexp);
        break;
      end
      if (!rv_hold) bus.rvalid = (sk < nsend) && (!rnd || $urandom_range(3) != 0);
      bus.rdata      = base + 32'(sk);
      bus.rlast      = (sk == last_idx);
      bus.rid        = (sk == bad_idx) ? 4'd5 : 4'd0;
      bus.rresp      = rresp;
      bus.resp_ready = (cyc < rr_hold) ? 1'b0 : (rnd ? 1'($urandom_range(1)) : 1'b1);
      check("rready", bus.rready, in_data && occ < 2);
      check("resp_valid", bus.resp_valid, occ > 0);
      hs  = bus.rvalid && bus.rready;
      pop = bus.resp_valid && bus.resp_ready;
      if (hs) begin
        if (acc >= nexp) check("extra_beat_accepted", acc, nexp);
        else begin
          acc++;
          sk++;
          if (acc == nexp) in_data = 1'b0;
        end
      end
      if (pop) begin
        if (popped < nexp) begin
          check("resp_data", bus.resp_data, exp_q[popped].data);
          check("resp_last", bus.resp_last, exp_q[popped].last);
          check("resp_err", bus.resp_err, exp_q[popped].err);
          popped++;
        end else check("spurious_pop", popped, nexp);
      end
      occ     = occ + int'(hs) - int'(pop);
      rv_hold = bus.rvalid && !hs;
      cyc++;
      @(posedge clk); @(negedge clk);
    end
    bus.rvalid     = 1'b0;
    bus.rlast      = 1'b0;
    bus.resp_ready = 1'b0;
    check("done_req_ready", bus.req_ready, 1);
    check("done_rready", bus.rready, 0);
    check("done_resp_valid", bus.resp_valid, 0);
    check("done_proto_err", bus.proto_err, exp_proto);
  endtask

  task automatic run_txn(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input int ar_delay, input int last_idx,
                         input int bad_idx, input logic [1:0] rresp, input logic [31:0] base,
                         input int rr_hold, input bit rnd);
    build_model(len, last_idx, bad_idx, rresp, base);
    issue_req(addr, len, size, burst, ar_delay);
    data_phase(len, last_idx, bad_idx, rresp, base, rr_hold, rnd);
  endtask

  initial begin
    int len, li, bi;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.req_size   = '0;
    bus.req_burst  = '0;
    bus.resp_ready = 1'b0;
    bus.arready    = 1'b0;
    bus.rvalid     = 1'b0;
    bus.rresp      = '0;
    bus.rdata      = '0;
    bus.rlast      = 1'b0;
    bus.rid        = '0;

    repeat (2) @(negedge clk);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_araddr", bus.araddr, 0);
    check("rst_arlen", bus.arlen, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rready", bus.rready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_proto_err", bus.proto_err, 0);
    check("rst_arid", bus.arid, 0);

    // Single beat with a slow AR handshake.
    run_txn(32'h0200_0000, 0, 3'd2, BURST_INCR, 3, 0, -1, RESP_OKAY, 32'h1234_5678, 0, 1'b0);
    // Four beats with the client stalled long enough to fill the buffer.
    run_txn(32'h0000_1000, 3, 3'd2, BURST_INCR, 0, 3, -1, RESP_OKAY, 32'h0000_00A0, 6, 1'b0);
    // Early rlast on beat 1.
    run_txn(32'h0000_2000, 3, 3'd2, BURST_INCR, 1, 1, -1, RESP_OKAY, 32'h0000_00B0, 0, 1'b0);
    // Slave error only.
    run_txn(32'h0000_3000, 0, 3'd2, BURST_FIXED, 0, 0, -1, RESP_SLVERR, 32'hC0DE_0000, 0, 1'b0);
    // ID mismatch.
    run_txn(32'h0000_4000, 0, 3'd2, BURST_INCR, 0, 0, 0, RESP_OKAY, 32'hC0DE_1000, 0, 1'b0);
    // Missing rlast on a two-beat burst.
    run_txn(32'h0000_5000, 1, 3'd1, BURST_WRAP, 2, -1, -1, RESP_OKAY, 32'hD000_0000, 0, 1'b0);

    // Asynchronous reset in the middle of a four-beat burst.
    issue_req(32'h0000_6000, 3, 3'd2, BURST_INCR, 0);
    bus.rvalid = 1'b1; bus.rdata = 32'hEE00_0000; bus.rlast = 1'b0;
    bus.rid = 4'd0; bus.rresp = RESP_OKAY; bus.resp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_beat0_buffered", bus.resp_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_arvalid", bus.arvalid, 0);
    check("mid_rst_rready", bus.rready, 0);
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    @(negedge clk);
    bus.rvalid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", bus.req_ready, 1);
    @(negedge clk);
    run_txn(32'h0000_7000, 0, 3'd2, BURST_INCR, 0, 0, -1, RESP_OKAY, 32'h5555_AAAA, 0, 1'b0);

    // Randomized bursts with random stalls, errors and last-beat faults.
    for (int t = 0; t < 16; t++) begin
      len = $urandom_range(7);
      li  = ($urandom_range(3) == 0) ? $urandom_range(len + 1) : len;
      bi  = ($urandom_range(7) == 0) ? $urandom_range(len) : -1;
      run_txn($urandom, len, 3'($urandom_range(3)), 2'($urandom_range(2)),
              $urandom_range(3), li, bi, 2'($urandom_range(3)), $urandom,
              $urandom_range(4), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
